// File: rtl/traffic_sensor_conditioner.sv
// traffic_sensor_conditioner
//   Turns the raw inductive-loop sensor into the registered demand flag that
//   feeds traffic_signal. The sensor is synchronized and debounced, and rising
//   edges of the filtered level are counted as vehicles over fixed windows.
//   Each window total drives a hysteresis demand flag. That flag only reaches
//   `traffic` while the controller shows YELLOW (or the illegal code 11), so
//   RED and GREEN phases always see one stable value.
//
// Parameters
//   DEBOUNCE  cycles a new synchronized level must persist (>=1)
//   WINDOW    observation window length in cycles (>=2)
//   HI_TH     window count at/above which demand asserts
//   LO_TH     window count at/below which demand deasserts
//   CW        vehicle counter width (saturating)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   sensor     raw asynchronous loop level, 1 = vehicle present
//   signal     light from traffic_signal: 00 RED, 01 YELLOW, 10 GREEN
//   traffic    registered demand flag
//   veh_count  saturated vehicle count of the last completed window
//   win_done   one-cycle pulse the cycle after a window closes
module traffic_sensor_conditioner #(
    parameter int DEBOUNCE = 3,
    parameter int WINDOW   = 64,
    parameter int HI_TH    = 4,
    parameter int LO_TH    = 2,
    parameter int CW       = 7
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sensor,
    input  logic [1:0]    signal,
    output logic          traffic,
    output logic [CW-1:0] veh_count,
    output logic          win_done
);

    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int WW = $clog2(WINDOW);

    localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE - 1);
    localparam logic [WW-1:0] W_LAST = WW'(WINDOW - 1);
    localparam logic [CW-1:0] HI     = CW'(HI_TH);
    localparam logic [CW-1:0] LO     = CW'(LO_TH);

    logic          s_meta;
    logic          s_sync;
    logic          db;
    logic          db_prev;
    logic [DW-1:0] dcnt;
    logic [WW-1:0] wcnt;
    logic [CW-1:0] acc;
    logic          demand;

    logic          veh;
    logic          win_last;
    logic [CW-1:0] total;

    // Event is combinational against the registered previous level, so it is
    // seen in the same cycle db first reads high. total includes that event
    // and never wraps past all-ones.
    always_comb begin
        veh      = db & ~db_prev;
        win_last = (wcnt == W_LAST);
        total    = (acc == '1) ? acc : acc + CW'(veh);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s_meta    <= 1'b0;
            s_sync    <= 1'b0;
            db        <= 1'b0;
            db_prev   <= 1'b0;
            dcnt      <= '0;
            wcnt      <= '0;
            acc       <= '0;
            demand    <= 1'b0;
            traffic   <= 1'b0;
            veh_count <= '0;
            win_done  <= 1'b0;
        end else begin
            s_meta  <= sensor;
            s_sync  <= s_meta;
            db_prev <= db;

            if (s_sync == db) begin
                dcnt <= '0;
            end else if (dcnt == D_LAST) begin
                db   <= s_sync;
                dcnt <= '0;
            end else begin
                dcnt <= dcnt + 1'b1;
            end

            win_done <= win_last;
            if (win_last) begin
                wcnt      <= '0;
                acc       <= '0;
                veh_count <= total;
                if (total >= HI) begin
                    demand <= 1'b1;
                end else if (total <= LO) begin
                    demand <= 1'b0;
                end
            end else begin
                wcnt <= wcnt + 1'b1;
                acc  <= total;
            end

            // YELLOW (01) and the illegal 11 both pass demand through.
            if (signal[0]) begin
                traffic <= demand;
            end
        end
    end

endmodule

// File: tb/tb_traffic_sensor_conditioner.sv
// tb_traffic_sensor_conditioner
//   Drives a default instance and a CW=3 instance with identical stimulus and
//   compares both against a cycle-level reference model: the sensor is seen
//   two cycles late, the filtered level flips once the last DEBOUNCE
//   synchronized samples all disagree with it, and each window total is an
//   unbounded vehicle tally clipped to the counter range.
module tb_traffic_sensor_conditioner;

    localparam int DEBOUNCE = 3;
    localparam int WINDOW   = 64;
    localparam int HI_TH    = 4;
    localparam int LO_TH    = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       sensor;
    logic [1:0] signal;

    logic       traffic_a, win_done_a;
    logic [6:0] veh_count_a;
    logic       traffic_b, win_done_b;
    logic [2:0] veh_count_b;

    int vectors    = 0;
    int miscompares = 0;

    traffic_sensor_conditioner #(
        .DEBOUNCE(DEBOUNCE), .WINDOW(WINDOW), .HI_TH(HI_TH), .LO_TH(LO_TH), .CW(7)
    ) dut_a (
        .clk(clk), .rst(rst), .sensor(sensor), .signal(signal),
        .traffic(traffic_a), .veh_count(veh_count_a), .win_done(win_done_a)
    );

    traffic_sensor_conditioner #(
        .DEBOUNCE(DEBOUNCE), .WINDOW(WINDOW), .HI_TH(HI_TH), .LO_TH(LO_TH), .CW(3)
    ) dut_b (
        .clk(clk), .rst(rst), .sensor(sensor), .signal(signal),
        .traffic(traffic_b), .veh_count(veh_count_b), .win_done(win_done_b)
    );

    always #5 clk = ~clk;

    // Reference model state
    bit m_sp0, m_sp1;
    bit m_hist[$];
    bit m_db, m_rose;
    int m_cnt, m_pos;
    bit m_demand, m_traffic, m_wd;
    int m_vc_a, m_vc_b;

    task automatic check(input string tag, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int clip(input int v, input int mx);
        return (v > mx) ? mx : v;
    endfunction

    task automatic model_step(input bit r, input bit s, input bit [1:0] sig);
        bit veh;
        bit all_diff;
        int total;
        if (r) begin
            m_sp0 = 0; m_sp1 = 0; m_db = 0; m_rose = 0;
            m_cnt = 0; m_pos = 0; m_demand = 0; m_traffic = 0; m_wd = 0;
            m_vc_a = 0; m_vc_b = 0;
            m_hist.delete();
            for (int i = 0; i < DEBOUNCE; i++) m_hist.push_back(1'b0);
            return;
        end
        veh = m_rose;
        if (sig[0]) m_traffic = m_demand;
        m_wd = 0;
        if (m_pos == WINDOW - 1) begin
            total  = m_cnt + int'(veh);
            m_vc_a = clip(total, 127);
            m_vc_b = clip(total, 7);
            m_wd   = 1;
            if (m_vc_a >= HI_TH) m_demand = 1;
            else if (m_vc_a <= LO_TH) m_demand = 0;
            m_cnt = 0;
            m_pos = 0;
        end else begin
            m_cnt += int'(veh);
            m_pos++;
        end
        m_hist.push_back(m_sp1);
        if (m_hist.size() > DEBOUNCE) void'(m_hist.pop_front());
        all_diff = 1;
        foreach (m_hist[i]) if (m_hist[i] == m_db) all_diff = 0;
        m_rose = 0;
        if (all_diff) begin
            m_db   = ~m_db;
            m_rose = m_db;
        end
        m_sp1 = m_sp0;
        m_sp0 = s;
    endtask

    // One clock: drive at the falling edge, step the model on the rising
    // edge, compare at the next falling edge.
    task automatic tick(input bit r, input bit s, input bit [1:0] sig);
        rst = r; sensor = s; signal = sig;
        @(posedge clk);
        model_step(r, s, sig);
        @(negedge clk);
        check("traffic",       int'(traffic_a),   int'(m_traffic));
        check("win_done",      int'(win_done_a),  int'(m_wd));
        check("veh_count",     int'(veh_count_a), m_vc_a);
        check("traffic_cw3",   int'(traffic_b),   int'(m_traffic));
        check("win_done_cw3",  int'(win_done_b),  int'(m_wd));
        check("veh_count_cw3", int'(veh_count_b), m_vc_b);
    endtask

    task automatic pulses(input int n, input int hi, input int lo, input bit [1:0] sig);
        for (int k = 0; k < n; k++) begin
            for (int j = 0; j < hi; j++) tick(1'b0, 1'b1, sig);
            for (int j = 0; j < lo; j++) tick(1'b0, 1'b0, sig);
        end
    endtask

    // Sensor low until the next window closes (bounded).
    task automatic finish_window(input bit [1:0] sig);
        int n;
        n = 0;
        do begin
            tick(1'b0, 1'b0, sig);
            n++;
        end while (!win_done_a && n < 3 * WINDOW);
        check("window_close_seen", int'(win_done_a), 1);
    endtask

    initial begin
        int n;
        bit s;
        bit [1:0] sig;
        int run;

        rst = 1'b1; sensor = 1'b0; signal = 2'b01;
        @(negedge clk);

        // Reset with a toggling sensor
        for (int i = 0; i < 3; i++) tick(1'b1, i[0], 2'b01);
        check("reset_traffic",   int'(traffic_a),   0);
        check("reset_veh_count", int'(veh_count_a), 0);
        check("reset_win_done",  int'(win_done_a),  0);
        tick(1'b0, 1'b0, 2'b01);

        // 2-cycle glitch is rejected
        pulses(1, 2, 0, 2'b01);
        finish_window(2'b01);
        check("glitch_count", int'(veh_count_a), 0);

        // 3-cycle pulse is accepted
        pulses(1, 3, 3, 2'b01);
        finish_window(2'b01);
        check("single_count", int'(veh_count_a), 1);

        // 5 vehicles asserts demand
        pulses(5, 4, 4, 2'b01);
        finish_window(2'b01);
        check("five_count", int'(veh_count_a), 5);
        tick(1'b0, 1'b0, 2'b01);
        check("assert_traffic", int'(traffic_a), 1);

        // Hysteresis: 3 holds, 1 releases
        pulses(3, 4, 4, 2'b01);
        finish_window(2'b01);
        check("three_count", int'(veh_count_a), 3);
        tick(1'b0, 1'b0, 2'b01);
        check("hyst_hold", int'(traffic_a), 1);
        pulses(1, 4, 4, 2'b01);
        finish_window(2'b01);
        tick(1'b0, 1'b0, 2'b01);
        check("hyst_release", int'(traffic_a), 0);

        // Freeze while GREEN, pass on YELLOW, freeze while RED
        pulses(5, 4, 4, 2'b10);
        finish_window(2'b10);
        tick(1'b0, 1'b0, 2'b10);
        check("freeze_green", int'(traffic_a), 0);
        tick(1'b0, 1'b0, 2'b01);
        check("yellow_pass", int'(traffic_a), 1);
        finish_window(2'b00);
        tick(1'b0, 1'b0, 2'b00);
        check("freeze_red", int'(traffic_a), 1);

        // Saturation: 8 vehicles in one window
        pulses(8, 3, 3, 2'b01);
        finish_window(2'b01);
        check("sat_cw7", int'(veh_count_a), 8);
        check("sat_cw3", int'(veh_count_b), 7);

        // Mid-window reset discards the partial window
        pulses(5, 3, 3, 2'b01);
        tick(1'b1, 1'b0, 2'b01);
        n = 0;
        do begin
            tick(1'b0, 1'b0, 2'b01);
            n++;
        end while (!win_done_a && n < 3 * WINDOW);
        check("reset_to_win_done", n, WINDOW);
        check("post_reset_count", int'(veh_count_a), 0);

        // Random traffic
        s = 1'b0; sig = 2'b01; run = 1;
        for (int i = 0; i < 2000; i++) begin
            run--;
            if (run <= 0) begin
                s = ~s;
                run = $urandom_range(1, 8);
            end
            if ($urandom_range(0, 9) == 0) sig = 2'($urandom);
            tick(($urandom_range(0, 499) == 0), s, sig);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/traffic_sensor_conditioner.md
# traffic_sensor_conditioner

Conditions the raw inductive-loop vehicle sensor into the `traffic` demand input of `traffic_signal`, the block directly downstream. Synchronizes and debounces the sensor, counts vehicles over fixed observation windows, applies hysteresis thresholds, and holds `traffic` stable while the controller is in RED or GREEN so each phase-length decision sees one consistent value.

## Interface
- `DEBOUNCE`, 3: consecutive synchronized cycles a new sensor level must persist before acceptance (≥1).
- `WINDOW`, 64: observation window length in clock cycles (≥2).
- `HI_TH`, 4: window vehicle count at or above which demand asserts.
- `LO_TH`, 2: window vehicle count at or below which demand deasserts (LO_TH < HI_TH ≤ 2^CW−1).
- `CW`, 7: vehicle counter width.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `sensor`  in  1  raw loop detector level, asynchronous and noisy; 1 = vehicle present.
- `signal`  in  2  current light from `traffic_signal`: RED=00, YELLOW=01, GREEN=10.
- `traffic`  out  1  registered demand flag to `traffic_signal`.
- `veh_count`  out  CW  registered vehicle count of the last completed window.
- `win_done`  out  1  one-cycle pulse, high the cycle after a window closes.

## Operation
- Synchronizer: two flops on `sensor` → `s_sync`. Both reset to 0.
- Debouncer: filtered level `db` (reset 0) and counter `dcnt` (reset 0). If `s_sync == db`, `dcnt` clears. Otherwise `dcnt` increments, and on the DEBOUNCE-th consecutive mismatch `db` takes `s_sync` and `dcnt` clears. A mismatch shorter than DEBOUNCE cycles is discarded.
- Vehicle event: `veh` = 1 for one cycle on each 0→1 transition of `db`. Falling edges are not counted.
- Window: `wcnt` counts 0..WINDOW−1 and wraps. Accumulator `acc` adds `veh` each cycle and saturates at 2^CW−1.
- When `wcnt == WINDOW−1`, at the next edge:
  - `total` = sat(`acc` + `veh`), so an event in the last cycle is included.
  - `veh_count` ← `total`; `acc` ← 0; `wcnt` ← 0; `win_done` ← 1.
- Hysteresis: internal `demand` (reset 0) updates at that same edge from `total`:
  - `total` ≥ HI_TH → 1.
  - `total` ≤ LO_TH → 0.
  - otherwise demand holds.
- Phase freeze: `traffic` ← `demand` on every edge where `signal` is YELLOW (01) or the illegal value 11. While RED or GREEN, `traffic` holds.
- Reset mid-operation: all registers return to reset values at the next edge regardless of window or debounce progress. The partial window is discarded and the next window starts with `wcnt` = 0.

## Timing
- Reset values: `traffic`=0, `veh_count`=0, `win_done`=0. Internals: `db`, `dcnt`, `wcnt`, `acc`, `demand` = 0.
- Sensor edge to `db` change: 2 (sync) + DEBOUNCE cycles. This is 5 cycles at default.
- `db` rising to `veh` pulse: same cycle `db` is first seen high, i.e. a combinational edge detect against a registered previous `db`.
- Window close to `veh_count`/`win_done`/`demand` valid: 1 edge. `win_done` is high exactly one cycle per WINDOW cycles; the first pulse comes WINDOW cycles after reset release.
- `demand` to `traffic`: 1 edge while YELLOW. If `signal` leaves YELLOW on the same edge `demand` changes, `traffic` keeps its old value until the next YELLOW.
- `veh_count` holds between window closes. Saturation never wraps.

## Test plan
- Reset: `rst`=1 for 3 cycles with `sensor` toggling every cycle → `traffic`=0, `veh_count`=0, `win_done`=0 throughout and on the first cycle after release.
- Debounce, 2-cycle glitch: 2-cycle sensor high pulse → no event, `veh_count`=0 at window close.
- Debounce, accepted pulse: 3-cycle high then ≥3 low → exactly 1 event, `veh_count`=1.
- Assert: 5 clean vehicles (4 high / 4 low) in one window with `signal`=01 → `veh_count`=5, `win_done` pulse, `traffic`=1 one cycle after `win_done`.
- Hysteresis: following windows of 3 then 1 vehicles with `signal`=01 → `traffic` stays 1 after the 3-vehicle window, drops to 0 after the 1-vehicle window.
- Freeze: `demand` rises while `signal`=10 → `traffic` stays 0. Drive `signal`=01 → `traffic`=1 on the next edge. Return to 00 with demand falling → `traffic` stays 1.
- Saturation and mid-window reset: with CW=3, 8 vehicles in a 64-cycle window → `veh_count`=7. Assert `rst` at `wcnt`≈30 → next `win_done` exactly 64 cycles after release and the count excludes pre-reset vehicles.
